// File: rtl/go_board_writer.sv
// Go board state owner: turns debounced button edges into cursor moves, stone
// placements and passes, and serves a 1-cycle-latency cell read port to the renderer.
module go_board_writer #(
  parameter int BOARD_SIZE = 9
) (
  input  logic       vclock_in,
  input  logic       reset_in,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       place_in,
  input  logic       pass_in,
  input  logic [3:0] rd_row_in,
  input  logic [3:0] rd_col_in,
  output logic [1:0] rd_data_out,
  output logic [3:0] cursor_row_out,
  output logic [3:0] cursor_col_out,
  output logic       turn_out,
  output logic [7:0] move_count_out,
  output logic       busy_out,
  output logic       placed_out,
  output logic       illegal_out,
  output logic       game_over_out,
  output logic [2:0] state_dbg_out
);

  localparam int CLEAR_CYCLES = BOARD_SIZE * BOARD_SIZE;
  localparam int IDX_W        = $clog2(CLEAR_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLEAR_CYCLES - 1);
  localparam logic [3:0]       MAX_POS  = 4'(BOARD_SIZE - 1);
  localparam logic [3:0]       MID_POS  = 4'(BOARD_SIZE / 2);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CHECK, S_WRITE, S_OVER} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cells [CLEAR_CYCLES];
  logic [IDX_W-1:0] r_clr_idx;
  logic [3:0]       r_row, r_col;
  logic             r_turn;
  logic [7:0]       r_move_count;
  logic [1:0]       r_pass_streak;
  logic [5:0]       r_prev;
  logic [1:0]       r_rd_data;

  logic [5:0]       w_btn, w_edge;
  logic [IDX_W-1:0] w_cur_idx, w_rd_idx;
  logic             w_rd_oob, w_occupied;
  logic             w_do_pass, w_do_up, w_do_down, w_do_left, w_do_right;
  logic             w_placed, w_illegal;

  // Button vector ordered by priority, highest in the MSB.
  assign w_btn  = {place_in, pass_in, up_in, down_in, left_in, right_in};
  assign w_edge = w_btn & ~r_prev;

  assign w_cur_idx  = IDX_W'(r_row) * IDX_W'(BOARD_SIZE) + IDX_W'(r_col);
  assign w_rd_idx   = IDX_W'(rd_row_in) * IDX_W'(BOARD_SIZE) + IDX_W'(rd_col_in);
  assign w_rd_oob   = (rd_row_in >= 4'(BOARD_SIZE)) || (rd_col_in >= 4'(BOARD_SIZE));
  assign w_occupied = (r_cells[w_cur_idx] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_do_pass   = 1'b0;
    w_do_up     = 1'b0;
    w_do_down   = 1'b0;
    w_do_left   = 1'b0;
    w_do_right  = 1'b0;
    w_placed    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_edge[5]) begin
          w_state_nxt = S_CHECK;
        end else if (w_edge[4]) begin
          w_do_pass = 1'b1;
          if (r_pass_streak == 2'd1) w_state_nxt = S_OVER;
        end else if (w_edge[3]) begin
          w_do_up = 1'b1;
        end else if (w_edge[2]) begin
          w_do_down = 1'b1;
        end else if (w_edge[1]) begin
          w_do_left = 1'b1;
        end else if (w_edge[0]) begin
          w_do_right = 1'b1;
        end
      end
      S_CHECK: begin
        w_illegal   = w_occupied;
        w_state_nxt = w_occupied ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        w_placed    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_OVER:  w_state_nxt = S_OVER;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge vclock_in) begin
    if (reset_in) begin
      r_state       <= S_CLEAR;
      r_clr_idx     <= '0;
      r_row         <= MID_POS;
      r_col         <= MID_POS;
      r_turn        <= 1'b0;
      r_move_count  <= 8'd0;
      r_pass_streak <= 2'd0;
      r_prev        <= w_btn;
      r_rd_data     <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_btn;
      r_rd_data <= (r_state == S_CLEAR || w_rd_oob) ? 2'b00 : r_cells[w_rd_idx];
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
      if (w_do_up    && r_row != 4'd0)    r_row <= r_row - 4'd1;
      if (w_do_down  && r_row != MAX_POS) r_row <= r_row + 4'd1;
      if (w_do_left  && r_col != 4'd0)    r_col <= r_col - 4'd1;
      if (w_do_right && r_col != MAX_POS) r_col <= r_col + 4'd1;
      if (w_do_pass) begin
        r_turn        <= ~r_turn;
        r_pass_streak <= r_pass_streak + 2'd1;
      end
      if (w_placed) begin
        r_turn        <= ~r_turn;
        r_move_count  <= r_move_count + 8'd1;
        r_pass_streak <= 2'd0;
      end
    end
  end

  // Cell array has no reset; the CLEAR sweep that follows every reset empties it.
  always_ff @(posedge vclock_in) begin
    if (!reset_in) begin
      if (r_state == S_CLEAR) r_cells[r_clr_idx] <= 2'b00;
      else if (w_placed)      r_cells[w_cur_idx] <= r_turn ? 2'b10 : 2'b01;
    end
  end

  assign rd_data_out    = r_rd_data;
  assign cursor_row_out = r_row;
  assign cursor_col_out = r_col;
  assign turn_out       = r_turn;
  assign move_count_out = r_move_count;
  assign busy_out       = (r_state == S_CLEAR);
  assign placed_out     = w_placed;
  assign illegal_out    = w_illegal;
  assign game_over_out  = (r_state == S_OVER);
  assign state_dbg_out  = r_state;

endmodule

// File: tb/tb_go_board_writer.sv
// Directed bench for go_board_writer: placed/illegal pulses are scored against an
// expected queue by a negedge monitor; status and board reads are checked inline.
module tb_go_board_writer;

  localparam logic [5:0] B_PLACE = 6'b100000;
  localparam logic [5:0] B_PASS  = 6'b010000;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_LEFT  = 6'b000010;
  localparam logic [5:0] B_RIGHT = 6'b000001;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       up_in, down_in, left_in, right_in, place_in, pass_in;
  logic [3:0] rd_row_in, rd_col_in;
  logic [1:0] rd_data_out;
  logic [3:0] cursor_row_out, cursor_col_out;
  logic       turn_out;
  logic [7:0] move_count_out;
  logic       busy_out, placed_out, illegal_out, game_over_out;
  logic [2:0] state_dbg_out;

  int n_tests = 0;
  int n_fail  = 0;
  // Event record: {placed, illegal, cursor_row, cursor_col}
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  go_board_writer #(.BOARD_SIZE(9)) dut (
    .vclock_in(clk), .reset_in(reset_in),
    .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
    .place_in(place_in), .pass_in(pass_in),
    .rd_row_in(rd_row_in), .rd_col_in(rd_col_in), .rd_data_out(rd_data_out),
    .cursor_row_out(cursor_row_out), .cursor_col_out(cursor_col_out),
    .turn_out(turn_out), .move_count_out(move_count_out), .busy_out(busy_out),
    .placed_out(placed_out), .illegal_out(illegal_out),
    .game_over_out(game_over_out), .state_dbg_out(state_dbg_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [5:0] b);
    {place_in, pass_in, up_in, down_in, left_in, right_in} = b;
  endtask

  task automatic press(input logic [5:0] b);
    set_btn(b);
    tick();
    set_btn(6'b0);
    tick();
  endtask

  task automatic press_n(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic check_cursor(input string name, input logic [3:0] r, input logic [3:0] c);
    check({name, "_row"}, cursor_row_out, r);
    check({name, "_col"}, cursor_col_out, c);
  endtask

  task automatic rd(input string name, input logic [3:0] r, input logic [3:0] c,
                    input logic [1:0] exp);
    rd_row_in = r;
    rd_col_in = c;
    tick();
    check(name, rd_data_out, exp);
  endtask

  // Place edge in cycle T: CHECK in T+1, WRITE (placed pulse) in T+2.
  task automatic place(input string name, input logic [5:0] extra, input logic ok,
                       input logic [3:0] r, input logic [3:0] c);
    exp_q.push_back({ok, ~ok, r, c});
    set_btn(B_PLACE | extra);
    tick();
    set_btn(6'b0);
    check({name, "_placed_t1"}, placed_out, 0);
    check({name, "_illegal_t1"}, illegal_out, !ok);
    tick();
    check({name, "_placed_t2"}, placed_out, ok);
    check({name, "_illegal_t2"}, illegal_out, 0);
    tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 300 && busy_out; i++) begin
      n++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] got;
    logic [9:0] exp;
    if (placed_out || illegal_out) begin
      got = {placed_out, illegal_out, cursor_row_out, cursor_col_out};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL event: got %h expected %h", got, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset_in  = 1'b1;
    set_btn(6'b0);
    rd_row_in = 4'd0;
    rd_col_in = 4'd0;
    tick(); tick(); tick();
    check("rst_busy", busy_out, 1);
    check("rst_placed", placed_out, 0);
    check("rst_illegal", illegal_out, 0);
    check("rst_over", game_over_out, 0);
    check("rst_rd", rd_data_out, 0);
    check_cursor("rst_cursor", 4'd4, 4'd4);
    check("rst_turn", turn_out, 0);
    check("rst_count", move_count_out, 0);
    reset_in = 1'b0;
    count_busy(nb);
    check("clear_busy_cycles", nb, 81);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        rd("clear_cell", 4'(r), 4'(c), 2'b00);
    check_cursor("idle_cursor", 4'd4, 4'd4);
    check("idle_turn", turn_out, 0);

    press_n(B_UP, 6);
    check_cursor("up_sat", 4'd0, 4'd4);
    press_n(B_RIGHT, 6);
    check_cursor("right_sat", 4'd0, 4'd8);
    press(B_UP);
    press(B_RIGHT);
    check_cursor("limit_hold", 4'd0, 4'd8);
    press(B_DOWN | B_LEFT);
    check_cursor("down_over_left", 4'd1, 4'd8);
    press(B_LEFT);
    check_cursor("left", 4'd1, 4'd7);
    press_n(B_DOWN, 3);
    press_n(B_LEFT, 3);
    check_cursor("back_center", 4'd4, 4'd4);

    rd_row_in = 4'd4;
    rd_col_in = 4'd4;
    place("place_44", 6'b0, 1'b1, 4'd4, 4'd4);
    check("rd_old_at_write", rd_data_out, 2'b00);
    tick();
    check("rd_new_after_write", rd_data_out, 2'b01);
    check("turn_after_1", turn_out, 1);
    check("count_after_1", move_count_out, 1);

    press(B_RIGHT);
    place("place_45", 6'b0, 1'b1, 4'd4, 4'd5);
    rd("cell_45_white", 4'd4, 4'd5, 2'b10);
    check("count_after_2", move_count_out, 2);
    check("turn_after_2", turn_out, 0);

    press(B_LEFT);
    place("place_44_again", 6'b0, 1'b0, 4'd4, 4'd4);
    rd("cell_44_kept", 4'd4, 4'd4, 2'b01);
    check("turn_after_illegal", turn_out, 0);
    check("count_after_illegal", move_count_out, 2);

    press(B_UP);
    place("place_up_same_cycle", B_UP, 1'b1, 4'd3, 4'd4);
    check_cursor("place_beats_up", 4'd3, 4'd4);
    rd("cell_34", 4'd3, 4'd4, 2'b01);
    check("count_after_3", move_count_out, 3);
    rd("oob_col", 4'd3, 4'd13, 2'b00);
    rd("oob_row", 4'd9, 4'd0, 2'b00);

    press(B_PASS | B_UP);
    check("pass_turn", turn_out, 0);
    check_cursor("pass_beats_up", 4'd3, 4'd4);
    press(B_LEFT);
    place("place_33", 6'b0, 1'b1, 4'd3, 4'd3);
    press(B_PASS);
    check("pass_place_pass_over", game_over_out, 0);
    check("turn_after_pass", turn_out, 0);
    press(B_PASS);
    check("two_pass_over", game_over_out, 1);
    check("turn_over", turn_out, 1);
    press(B_PLACE);
    press(B_UP);
    press(B_PASS);
    check_cursor("over_cursor_frozen", 4'd3, 4'd3);
    check("over_count", move_count_out, 4);
    check("over_turn", turn_out, 1);
    check("over_stays", game_over_out, 1);
    rd("over_read", 4'd3, 4'd3, 2'b01);

    set_btn(B_PLACE);
    reset_in = 1'b1;
    tick();
    check("reset_clears_over", game_over_out, 0);
    check("reset2_count", move_count_out, 0);
    tick();
    reset_in = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    reset_in = 1'b1;
    tick(); tick();
    reset_in = 1'b0;
    count_busy(nb);
    check("midclear_busy_cycles", nb, 81);
    tick(); tick();
    check("held_place_count", move_count_out, 0);
    check("held_place_turn", turn_out, 0);
    set_btn(6'b0);
    rd("cleared_33", 4'd3, 4'd3, 2'b00);
    rd("cleared_44", 4'd4, 4'd4, 2'b00);
    place("place_after_reset", 6'b0, 1'b1, 4'd4, 4'd4);
    check("count_after_reset_place", move_count_out, 1);

    tick(); tick(); tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
